// File: rtl/textlcd_pkg.sv
// Shared definitions for the text LCD responder: state codes, instruction bit map, address helpers.
// Pure combinational helpers, no latency; no flow control.
// Callers must only step AC or map AC to a DDRAM cell through these functions.
package textlcd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    // Instruction opcode is the highest set bit of the byte.
    localparam int INS_SET_DDRAM = 7;
    localparam int INS_SET_CGRAM = 6;
    localparam int INS_FUNC      = 5;
    localparam int INS_SHIFT     = 4;
    localparam int INS_DISP      = 3;
    localparam int INS_ENTRY     = 2;
    localparam int INS_HOME      = 1;
    localparam int INS_CLEAR     = 0;
    localparam int FUNC_N        = 3;
    localparam int DISP_D        = 2;
    localparam int ENTRY_I       = 1;

    localparam logic [7:0] BLANK      = 8'h20;
    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] LINE0_LAST = 7'h27;
    localparam logic [6:0] LINE1_LAST = 7'h67;
    localparam logic [6:0] ONE_LAST   = 7'h4F;

    typedef struct packed {
        logic       vld;
        logic [4:0] idx;
    } cell_t;

    function automatic logic [6:0] ac_next(input logic [6:0] a, input logic inc, input logic two);
        logic [6:0] r;
        r = inc ? a + 7'd1 : a - 7'd1;
        if (two) begin
            if (inc && a == LINE0_LAST)       r = LINE1_BASE;
            else if (inc && a == LINE1_LAST)  r = LINE0_BASE;
            else if (!inc && a == LINE1_BASE) r = LINE0_LAST;
            else if (!inc && a == LINE0_BASE) r = LINE1_LAST;
        end else begin
            if (inc && a == ONE_LAST)         r = LINE0_BASE;
            else if (!inc && a == LINE0_BASE) r = ONE_LAST;
        end
        return r;
    endfunction

    // Only the first 16 columns of each line are backed by storage.
    function automatic cell_t ac_to_index(input logic [6:0] a);
        cell_t c;
        c.vld = (a[5:4] == 2'b00);
        c.idx = {a[6], a[3:0]};
        return c;
    endfunction

endpackage

// File: rtl/textlcd_ddram.sv
// 32x8 display RAM: one write port, combinational bus read, registered checker read.
// Bus read 0 cycles, checker read 1 cycle (read-before-write on same index).
// No flow control; a write is taken every cycle we is high.
module textlcd_ddram (
    input  logic       clk,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [7:0] wdat,
    input  logic [4:0] bus_addr,
    output logic [7:0] bus_dat,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_dat
);

    logic [7:0] mem [0:31];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdat;
        end
        rd_dat <= mem[rd_addr];
    end

    assign bus_dat = mem[bus_addr];

endmodule

// File: rtl/textlcd_responder.sv
// Panel-side model of the 8-bit text LCD bus: instruction decode, DDRAM, AC and busy flag.
// Strobe commits 3 clk after lcd_e falls; read data valid while synced E is high.
// Strobes arriving while not idle are dropped and flagged with a one-cycle cmd_err.
module textlcd_responder
    import textlcd_pkg::*;
#(
    parameter int BUSY_CYCLES = 4,
    parameter int HOME_CYCLES = 40
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       busy,
    output logic       disp_on,
    output logic [6:0] ac,
    output logic       cmd_err,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char
);

    localparam int CNT_MAX = (BUSY_CYCLES > HOME_CYCLES) ? BUSY_CYCLES : HOME_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic             e_s1, e_s2, e_d;
    logic             cap_rs, cap_rw;
    logic [7:0]       cap_dat;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       fill_idx;
    logic             incr, two_line;
    logic             strobe, accept, clearing, rd_drive;
    cell_t            ac_cell;
    logic [7:0]       bus_dat;
    logic             mem_we;
    logic [4:0]       mem_waddr;
    logic [7:0]       mem_wdat;

    assign strobe    = e_d & ~e_s2;
    assign accept    = strobe & (state == ST_IDLE);
    assign clearing  = (state == ST_CLEAR);
    assign busy      = (state != ST_IDLE);
    assign ac_cell   = ac_to_index(ac);
    assign mem_we    = clearing | (accept & cap_rs & ~cap_rw & ac_cell.vld);
    assign mem_waddr = clearing ? fill_idx : ac_cell.idx;
    assign mem_wdat  = clearing ? BLANK : cap_dat;
    // e_s1 is next cycle's synced E, so the registered drive lines up with it.
    assign rd_drive  = e_s1 & lcd_rw;

    textlcd_ddram u_ddram (
        .clk      (clk),
        .we       (mem_we),
        .waddr    (mem_waddr),
        .wdat     (mem_wdat),
        .bus_addr (ac_cell.idx),
        .bus_dat  (bus_dat),
        .rd_addr  (rd_addr),
        .rd_dat   (rd_char)
    );

    always_ff @(posedge clk) begin
        if (resetn) begin
            e_s1 <= 1'b0;
            e_s2 <= 1'b0;
            e_d  <= 1'b0;
        end else begin
            e_s1 <= lcd_e;
            e_s2 <= e_s1;
            e_d  <= e_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (e_s2) begin
            cap_rs  <= lcd_rs;
            cap_rw  <= lcd_rw;
            cap_dat <= lcd_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            lcd_data_oe  <= 1'b0;
            lcd_data_out <= 8'h00;
        end else begin
            lcd_data_oe <= rd_drive;
            if (!rd_drive)   lcd_data_out <= 8'h00;
            else if (lcd_rs) lcd_data_out <= ac_cell.vld ? bus_dat : BLANK;
            else             lcd_data_out <= {busy, ac};
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state    <= ST_CLEAR;
            fill_idx <= '0;
            cnt      <= '0;
            ac       <= '0;
            disp_on  <= 1'b0;
            incr     <= 1'b1;
            two_line <= 1'b1;
            cmd_err  <= 1'b0;
        end else begin
            cmd_err <= strobe & (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (cap_rw) begin
                            if (cap_rs) ac <= ac_next(ac, incr, two_line);
                        end else if (cap_rs) begin
                            ac    <= ac_next(ac, incr, two_line);
                            state <= ST_BUSY;
                            cnt   <= CNT_W'(BUSY_CYCLES - 1);
                        end else begin
                            state <= ST_BUSY;
                            cnt   <= CNT_W'(BUSY_CYCLES - 1);
                            if (cap_dat[INS_SET_DDRAM])      ac <= cap_dat[6:0];
                            else if (cap_dat[INS_SET_CGRAM]) begin end
                            else if (cap_dat[INS_FUNC])      two_line <= cap_dat[FUNC_N];
                            else if (cap_dat[INS_SHIFT])     begin end
                            else if (cap_dat[INS_DISP])      disp_on <= cap_dat[DISP_D];
                            else if (cap_dat[INS_ENTRY])     incr <= cap_dat[ENTRY_I];
                            else if (cap_dat[INS_HOME]) begin
                                ac  <= '0;
                                cnt <= CNT_W'(HOME_CYCLES - 1);
                            end else if (cap_dat[INS_CLEAR]) begin
                                state    <= ST_CLEAR;
                                fill_idx <= '0;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) state <= ST_IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                ST_CLEAR: begin
                    if (fill_idx == 5'd31) begin
                        ac    <= '0;
                        incr  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        fill_idx <= fill_idx + 5'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_textlcd_responder.sv
// Bench for textlcd_responder: directed bus cycles plus a random mix, all compared
// against a behavioural panel model held in plain arrays and integers.
module tb_textlcd_responder;

    localparam int BUSY_CYCLES  = 4;
    localparam int HOME_CYCLES  = 40;
    localparam int CLEAR_CYCLES = 32;

    logic       clk = 1'b0;
    logic       resetn;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data_in;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;
    logic       busy;
    logic       disp_on;
    logic [6:0] ac;
    logic       cmd_err;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;

    always #5 clk = ~clk;

    textlcd_responder #(.BUSY_CYCLES(BUSY_CYCLES), .HOME_CYCLES(HOME_CYCLES)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .lcd_e        (lcd_e),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_data_in  (lcd_data_in),
        .lcd_data_out (lcd_data_out),
        .lcd_data_oe  (lcd_data_oe),
        .busy         (busy),
        .disp_on      (disp_on),
        .ac           (ac),
        .cmd_err      (cmd_err),
        .rd_addr      (rd_addr),
        .rd_char      (rd_char)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [7:0] m_mem [32];
    int         m_ac;
    bit         m_inc, m_two, m_disp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_idx(input int a);
        if (a < 16) return a;
        if (a >= 64 && a < 80) return a - 48;
        return -1;
    endfunction

    function automatic int m_step(input int a, input bit inc, input bit two);
        if (two) begin
            if (inc) return (a == 'h27) ? 'h40 : (a == 'h67) ? 0 : (a + 1) % 128;
            return (a == 'h40) ? 'h27 : (a == 0) ? 'h67 : (a + 127) % 128;
        end
        if (inc) return (a == 'h4F) ? 0 : (a + 1) % 128;
        return (a == 0) ? 'h4F : (a + 127) % 128;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_ac  = 0;
        m_inc = 1'b1;
    endtask

    task automatic m_data(input logic [7:0] d);
        int idx;
        idx = m_idx(m_ac);
        if (idx >= 0) m_mem[idx] = d;
        m_ac = m_step(m_ac, m_inc, m_two);
    endtask

    task automatic m_instr(input logic [7:0] d, output int cyc);
        cyc = BUSY_CYCLES;
        if (d >= 8'h80)      m_ac = int'(d) - 128;
        else if (d >= 8'h40) begin end
        else if (d >= 8'h20) m_two = d[3];
        else if (d >= 8'h10) begin end
        else if (d >= 8'h08) m_disp = d[2];
        else if (d >= 8'h04) m_inc = d[1];
        else if (d >= 8'h02) begin m_ac = 0; cyc = HOME_CYCLES; end
        else if (d == 8'h01) begin m_clear(); cyc = CLEAR_CYCLES; end
    endtask

    task automatic strobe(input bit rs, input bit rw, input logic [7:0] d, input int hi);
        lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_e = 1'b1;
        repeat (hi) @(negedge clk);
        lcd_e = 1'b0;
    endtask

    task automatic wr(input bit rs, input logic [7:0] d, output int nb);
        strobe(rs, 1'b0, d, 3);
        nb = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) nb++;
            else if (i >= 4) break;
        end
    endtask

    task automatic do_wr(input bit rs, input logic [7:0] d, input string tag);
        int nb, cyc;
        wr(rs, d, nb);
        if (rs) begin m_data(d); cyc = BUSY_CYCLES; end
        else m_instr(d, cyc);
        chk($sformatf("%s_busy", tag), nb, cyc);
        chk($sformatf("%s_ac", tag), ac, m_ac);
        chk($sformatf("%s_disp", tag), disp_on, m_disp);
    endtask

    task automatic rd(input bit rs, input string tag);
        int idx;
        logic [7:0] exp;
        idx = m_idx(m_ac);
        exp = rs ? ((idx >= 0) ? m_mem[idx] : 8'h20) : 8'(m_ac);
        lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        chk($sformatf("%s_oe_hi", tag), lcd_data_oe, 1'b1);
        chk($sformatf("%s_dout", tag), lcd_data_out, exp);
        lcd_e = 1'b0;
        repeat (4) @(negedge clk);
        if (rs) m_ac = m_step(m_ac, m_inc, m_two);
        chk($sformatf("%s_oe_lo", tag), lcd_data_oe, 1'b0);
        chk($sformatf("%s_ac", tag), ac, m_ac);
        chk($sformatf("%s_busy", tag), busy, 1'b0);
        lcd_rw = 1'b0;
    endtask

    task automatic chk_cells(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            @(negedge clk);
            chk($sformatf("%s_cell%0d", tag, i), rd_char, m_mem[i]);
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            n++;
            @(negedge clk);
        end
    endtask

    // Two data strobes: the second one's E rises after `gap` low cycles.
    task automatic burst(input int gap, input logic [7:0] d1, input logic [7:0] d2);
        int nerr;
        bit acc2;
        lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data_in = d1; lcd_e = 1'b1;
        repeat (2) @(negedge clk);
        lcd_e = 1'b0;
        repeat (gap) @(negedge clk);
        lcd_data_in = d2; lcd_e = 1'b1;
        @(negedge clk);
        lcd_e = 1'b0;
        nerr = 0;
        repeat (20) begin
            @(negedge clk);
            if (cmd_err) nerr++;
        end
        acc2 = (gap >= BUSY_CYCLES);
        m_data(d1);
        if (acc2) m_data(d2);
        chk($sformatf("burst%0d_cmd_err", gap), nerr, acc2 ? 0 : 1);
        chk($sformatf("burst%0d_ac", gap), ac, m_ac);
        chk($sformatf("burst%0d_idle", gap), busy, 1'b0);
    endtask

    initial begin
        string s;
        int    nb;
        int    op;
        logic [6:0] a;

        resetn = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
        lcd_data_in = 8'h00; rd_addr = 5'd0;
        m_clear(); m_two = 1'b1; m_disp = 1'b0;

        repeat (32) @(negedge clk);
        chk("rst_busy", busy, 1'b1);
        chk("rst_ac", ac, 7'h00);
        chk("rst_disp", disp_on, 1'b0);
        chk("rst_cmd_err", cmd_err, 1'b0);
        chk("rst_oe", lcd_data_oe, 1'b0);
        chk("rst_dout", lcd_data_out, 8'h00);
        resetn = 1'b0;
        count_busy(nb);
        chk("rst_fill_len", nb, CLEAR_CYCLES);
        chk_cells("rst");

        do_wr(1'b0, 8'h3C, "fset");
        do_wr(1'b0, 8'h0C, "dctl");
        do_wr(1'b0, 8'h06, "entry");
        do_wr(1'b0, 8'h80, "ac0");
        s = "Rotating...";
        for (int i = 0; i < s.len(); i++) do_wr(1'b1, s[i], "txt");
        chk("txt_ac_lit", ac, 7'h0B);
        chk("txt_disp_lit", disp_on, 1'b1);
        chk_cells("txt");

        do_wr(1'b0, 8'hA7, "ac27");
        do_wr(1'b1, 8'h58, "wr_x");
        do_wr(1'b1, 8'h59, "wr_y");
        chk("wrap_ac_lit", ac, 7'h41);
        rd_addr = 5'd16;
        @(negedge clk);
        chk("wrap_y_lit", rd_char, 8'h59);
        chk_cells("wrap");

        burst(2, 8'h61, 8'h62);
        burst(3, 8'h63, 8'h64);
        burst(4, 8'h65, 8'h66);
        chk_cells("burst");

        do_wr(1'b0, 8'hC5, "ac45");
        do_wr(1'b1, 8'h51, "wr_q");
        do_wr(1'b0, 8'hC5, "ac45b");
        rd(1'b0, "stat");
        chk("stat_ac_lit", ac, 7'h45);
        rd(1'b1, "drd");
        chk("drd_ac_lit", ac, 7'h46);
        do_wr(1'b0, 8'h90, "ac10");
        rd(1'b1, "drd_blank");

        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0: begin
                    if ($urandom_range(0, 1) == 1) a = 7'($urandom_range(0, 127));
                    else a = (($urandom_range(0, 1) == 1) ? 7'h27 : 7'h4F) - 7'($urandom_range(0, 2));
                    do_wr(1'b0, {1'b1, a}, "r_setac");
                end
                1: do_wr(1'b0, {6'b000001, 1'($urandom_range(0, 1)), 1'b0}, "r_entry");
                2: do_wr(1'b0, {4'b0011, 1'($urandom_range(0, 1)), 3'b000}, "r_func");
                3: do_wr(1'b0, 8'h02, "r_home");
                4, 5: rd(1'b1, "r_rd");
                default: do_wr(1'b1, 8'($urandom_range(33, 126)), "r_data");
            endcase
        end
        chk_cells("rand");

        do_wr(1'b0, 8'h01, "clr");
        chk_cells("clr");
        do_wr(1'b1, 8'h48, "hi_h");
        do_wr(1'b1, 8'h69, "hi_i");

        strobe(1'b0, 1'b0, 8'h01, 3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        chk("clr2_started", busy, 1'b1);
        repeat (10) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        m_clear(); m_two = 1'b1; m_disp = 1'b0;
        count_busy(nb);
        chk("rst_mid_fill_len", nb, CLEAR_CYCLES);
        chk("rst_mid_ac", ac, 7'h00);
        chk("rst_mid_disp", disp_on, 1'b0);
        chk_cells("rst_mid");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
